// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared types, widths and helpers for the readout event path
package ro_pkg;

  localparam int CNT_W_DEF = 17;
  localparam int CH_W      = 5;

  // Event record is packed as {chan, pol, pol_eve, ts}; ts width is per instance.
  function automatic int ev_width(input int ts_w);
    return CH_W + 2 + ts_w;
  endfunction

  // Index of the lowest set bit; callers handle v == 0 themselves.
  function automatic logic [CH_W-1:0] ctz(input logic [31:0] v);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = CH_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_event_fifo.sv
// rtl/ro_event_fifo.sv - show-ahead record FIFO, accepts a push when full if a pop happens in the same cycle
module ro_event_fifo
  import ro_pkg::*;
#(
  parameter int W     = 23,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (rd_en) rd_d = rd_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ro_event_deserializer.sv
// rtl/ro_event_deserializer.sv - slot-tracking sampler of the shared readout lines feeding an event FIFO
module ro_event_deserializer
  import ro_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = 17,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            line_pol,
  input  logic            line_pol_eve,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [4:0]      ev_chan,
  output logic            ev_pol,
  output logic            ev_pol_eve,
  output logic [TS_W-1:0] ev_ts,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  localparam int EW = CH_W + 2 + TS_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             guard_q, guard_d;
  logic             s_valid_q, s_valid_d;
  logic [CH_W-1:0]  s_chan_q, s_chan_d;
  logic             s_pol_q, s_pol_d, s_pe_q, s_pe_d;
  logic [TS_W-1:0]  s_ts_q, s_ts_d;
  logic             push_q, push_d;
  logic [EW-1:0]    push_data_q, push_data_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic [CH_W-1:0]  owner;
  logic             owner_ok, sample, pop, drop;
  logic [EW-1:0]    head;
  logic             full, empty;

  // Count zero means the MSB of the gray counter toggled at the last edge.
  assign owner    = (cnt_q == '0) ? CH_W'(CNT_W - 1) : ctz(32'(cnt_q));
  assign owner_ok = (32'(owner) < 32'(NCH));
  assign sample   = en && owner_ok && !(guard_q && (cnt_q == '0));
  assign pop      = ev_valid && ev_ready;
  assign drop     = push_q && full && !pop;

  always_comb begin
    cnt_d       = en ? cnt_q + CNT_W'(1) : cnt_q;
    guard_d     = en ? 1'b0 : guard_q;
    s_valid_d   = sample;
    s_chan_d    = sample ? owner : s_chan_q;
    s_pol_d     = sample ? line_pol : s_pol_q;
    s_pe_d      = sample ? line_pol_eve : s_pe_q;
    s_ts_d      = sample ? cnt_q[TS_W-1:0] : s_ts_q;
    // All-zero samples are idle slots and never reach the FIFO.
    push_d      = s_valid_q && (s_pol_q || s_pe_q);
    push_data_d = {s_chan_q, s_pol_q, s_pe_q, s_ts_q};
    overflow_d  = overflow_q || drop;
    drop_d      = (drop && (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      guard_q     <= 1'b1;
      s_valid_q   <= 1'b0;
      s_chan_q    <= '0;
      s_pol_q     <= 1'b0;
      s_pe_q      <= 1'b0;
      s_ts_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      s_valid_q   <= s_valid_d;
      s_chan_q    <= s_chan_d;
      s_pol_q     <= s_pol_d;
      s_pe_q      <= s_pe_d;
      s_ts_q      <= s_ts_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  ro_event_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (ev_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign ev_valid = !empty;
  assign {ev_chan, ev_pol, ev_pol_eve, ev_ts} = empty ? '0 : head;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ro_event_deserializer.sv
// tb/tb_ro_event_deserializer.sv - randomized bench against a queue-based event model, two parameter sets
module tb_ro_event_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, line_pol, line_pol_eve, ev_ready;

  logic        a_valid, a_pol, a_pe, a_ovf;
  logic [4:0]  a_chan;
  logic [15:0] a_ts;
  logic [7:0]  a_drop;
  logic        b_valid, b_pol, b_pe, b_ovf;
  logic [4:0]  b_chan;
  logic [5:0]  b_ts;
  logic [7:0]  b_drop;

  ro_event_deserializer #(.CNT_W(17), .NCH(17), .TS_W(16), .DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .line_pol(line_pol), .line_pol_eve(line_pol_eve),
    .ev_valid(a_valid), .ev_ready(ev_ready), .ev_chan(a_chan), .ev_pol(a_pol),
    .ev_pol_eve(a_pe), .ev_ts(a_ts), .overflow(a_ovf), .drop_cnt(a_drop)
  );

  ro_event_deserializer #(.CNT_W(6), .NCH(4), .TS_W(6), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .line_pol(line_pol), .line_pol_eve(line_pol_eve),
    .ev_valid(b_valid), .ev_ready(ev_ready), .ev_chan(b_chan), .ev_pol(b_pol),
    .ev_pol_eve(b_pe), .ev_ts(b_ts), .overflow(b_ovf), .drop_cnt(b_drop)
  );

  typedef struct {
    int inst;
    int due;
    int chan;
    int pol;
    int pe;
    int ts;
  } ev_t;

  function automatic int p_cntw(input int i); return (i == 0) ? 17 : 6; endfunction
  function automatic int p_nch(input int i);  return (i == 0) ? 17 : 4; endfunction
  function automatic int p_tsw(input int i);  return (i == 0) ? 16 : 6; endfunction
  function automatic int p_depth(input int i); return (i == 0) ? 8 : 4; endfunction

  // Channel that owns the bus for a given slot count: lowest set bit, MSB when zero.
  function automatic int owner_of(input int c, input int w);
    for (int i = 0; i < w; i++) if (((c >> i) & 1) != 0) return i;
    return w - 1;
  endfunction

  ev_t pend[$];
  ev_t fq[2][0:7];
  int  m_cnt[2], m_guard[2], m_head[2], m_n[2], m_ovf[2], m_drop[2];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      pend.delete();
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_guard[i] = 1; m_head[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit  popped, got, was_full;
        ev_t a;
        int  owner;
        popped = (m_n[i] > 0) && ev_ready;
        got = 0;
        for (int j = pend.size() - 1; j >= 0; j--) begin
          if (pend[j].inst == i && pend[j].due == cyc) begin
            a = pend[j];
            got = 1;
            pend.delete(j);
          end
        end
        was_full = (m_n[i] == p_depth(i));
        if (popped) begin
          m_head[i] = (m_head[i] + 1) % p_depth(i);
          m_n[i]    = m_n[i] - 1;
        end
        if (got) begin
          if (was_full && !popped) begin
            m_ovf[i] = 1;
            if (m_drop[i] < 255) m_drop[i] = m_drop[i] + 1;
          end else begin
            fq[i][(m_head[i] + m_n[i]) % p_depth(i)] = a;
            m_n[i] = m_n[i] + 1;
          end
        end
        if (en) begin
          owner = owner_of(m_cnt[i], p_cntw(i));
          if (owner < p_nch(i) && !(m_guard[i] == 1 && m_cnt[i] == 0) && (line_pol || line_pol_eve)) begin
            a.inst = i; a.due = cyc + 2; a.chan = owner;
            a.pol = int'(line_pol); a.pe = int'(line_pol_eve);
            a.ts = m_cnt[i] % (1 << p_tsw(i));
            pend.push_back(a);
          end
          m_guard[i] = 0;
          m_cnt[i] = (m_cnt[i] + 1) % (1 << p_cntw(i));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_head(input int i);
    ev_t h;
    if (m_n[i] == 0) return 32'd0;
    h = fq[i][m_head[i]];
    return 32'((h.chan << (p_tsw(i) + 2)) | (h.pol << (p_tsw(i) + 1)) | (h.pe << p_tsw(i)) | h.ts);
  endfunction

  task automatic check_all();
    check("a_valid", 32'(a_valid), 32'(m_n[0] > 0));
    check("a_head", 32'({a_chan, a_pol, a_pe, a_ts}), exp_head(0));
    check("a_overflow", 32'(a_ovf), 32'(m_ovf[0]));
    check("a_drop_cnt", 32'(a_drop), 32'(m_drop[0]));
    check("b_valid", 32'(b_valid), 32'(m_n[1] > 0));
    check("b_head", 32'({b_chan, b_pol, b_pe, b_ts}), exp_head(1));
    check("b_overflow", 32'(b_ovf), 32'(m_ovf[1]));
    check("b_drop_cnt", 32'(b_drop), 32'(m_drop[1]));
  endtask

  task automatic run(input int n, input int p_line, input int p_ready, input int p_en);
    for (int k = 0; k < n; k++) begin
      line_pol     = ($urandom_range(99) < p_line);
      line_pol_eve = ($urandom_range(99) < p_line);
      ev_ready     = ($urandom_range(99) < p_ready);
      en           = ($urandom_range(99) < p_en);
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; line_pol = 1'b0; line_pol_eve = 1'b0; ev_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    reset = 1'b0;
    run(64, 0, 50, 100);
    run(40, 100, 100, 100);
    run(800, 30, 60, 90);
    run(400, 90, 0, 100);
    run(300, 50, 80, 95);
    run(30, 80, 0, 100);
    reset = 1'b1;
    @(negedge clk);
    check_all();
    reset = 1'b0;
    run(20, 100, 100, 100);
    run(1000, 40, 50, 85);
    run(50, 0, 100, 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_event_deserializer.md
Name: ro_event_deserializer

Overview:
- Downstream consumer of the shared tristate readout lines driven by the per-channel readout blocks (pol and pol_eve lines).
- Runs a local slot counter in lockstep with the global gray counter, so it knows which readout channel owns the bus each cycle.
- Samples both lines, tags non-zero samples with channel index and timestamp, and buffers them in a small FIFO behind a valid/ready interface for the off-chip link.

Parameters:
- CNT_W, 17, slot counter width; must equal the global gray counter width.
- NCH, 17, number of populated readout channels (1..CNT_W); channel indices >= NCH are ignored.
- TS_W, 16, timestamp width carried per event (TS_W <= CNT_W).
- DEPTH, 8, event FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  global master clock (same clock that drives the gray counter).
- reset  in  1  synchronous, active-high reset.
- en  in  1  count/sample enable; tied to the gray counter enable.
- line_pol  in  1  shared readout line, polarity channel.
- line_pol_eve  in  1  shared readout line, even-polarity channel.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event.
- ev_chan  out  5  channel index of the head event.
- ev_pol  out  1  sampled line_pol of the head event.
- ev_pol_eve  out  1  sampled line_pol_eve of the head event.
- ev_ts  out  TS_W  slot-counter timestamp of the head event.
- overflow  out  1  sticky: at least one event was dropped since reset.
- drop_cnt  out  8  count of dropped events, saturating at 255.

Behaviour:
- Reset (synchronous, active-high, on rising clk): cnt=0, FIFO empty, ev_valid=0, ev_chan/ev_pol/ev_pol_eve/ev_ts=0, overflow=0, drop_cnt=0. Reset asserted mid-operation discards all buffered events; there is no partial drain.
- Slot counter: on each rising clk with en=1, cnt <= cnt+1 mod 2^CNT_W. Holds when en=0. After reset, cnt tracks the binary equivalent of the gray counter.
- Owner decode is combinational from the current cnt, i.e. identifies the gray bit that toggled at the previous edge.
  - cnt != 0: owner = number of trailing zeros of cnt.
  - cnt == 0 (wrap, or first cycle after reset): owner = CNT_W-1, the MSB toggled.
- Sample stage: one register stage. On a rising clk with en=1, reset=0 and owner < NCH:
  - capture {owner, line_pol, line_pol_eve, cnt[TS_W-1:0]}.
  - Raise push next cycle only if line_pol or line_pol_eve is 1; all-zero samples are discarded (sparse events).
- Post-reset guard: the cnt==0 sample is suppressed once after reset, since no channel has driven yet.
- Latency: bus sample edge -> ev_valid high on an empty FIFO is 2 clk.
- FIFO behaviour:
  - Show-ahead, DEPTH entries.
  - A pop happens when ev_valid && ev_ready.
  - Push and pop in the same cycle when full: both succeed, nothing dropped.
  - Push when full without a pop: event dropped, overflow <= 1, drop_cnt <= min(drop_cnt+1, 255).
  - Pop when empty: no-op.
- Head event fields hold stable while ev_valid=1 and ev_ready=0.
- en=0 stops counting and sampling but not FIFO draining.

Decomposition:
- Shared package ro_pkg: CNT_W default, channel-index width (5), event record layout {chan, pol, pol_eve, ts}, function ctz().
- One natural sub-module: ro_event_fifo (parametric DEPTH×record show-ahead FIFO with full/empty and push/pop; overflow accounting stays in the top).

Test Plan:
- Reset, then en=1, lines held 0 for 64 cycles -> ev_valid never asserts; cnt=64; overflow=0.
- line_pol=1 only while owner=1 (cnt=2,6,10,...) for 16 cycles, ev_ready=1 -> 4 events with ev_chan=1, ev_pol=1, ev_pol_eve=0, ev_ts=2,6,10,14; each appears 2 clk after its sample edge.
- Both lines=1 for 8 cycles starting at cnt=1 -> ev_chan sequence 0,1,0,2,0,1,0,3, ev_ts=1..8, pol=pol_eve=1.
- ev_ready=0, lines=1 for 20 cycles, DEPTH=8 -> 8 events buffered, 12 dropped, overflow=1, drop_cnt=12; then ev_ready=1 drains exactly 8 events with ts 1..8.
- NCH=4, lines=1 continuously -> no event with ev_chan>=4. With CNT_W=17, wrap at cnt=0 -> owner 16 is filtered; the next event is ev_chan=0, ts=1.
- Assert reset for 1 cycle while FIFO holds 5 events -> next cycle ev_valid=0, drop_cnt=0, cnt=0; the first post-reset cnt=0 sample is suppressed.
